// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the buffered UART.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned MIN_DIVISOR = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Data narrower than 8 bits is zero-padded, which does not change the parity.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_buffered.sv
// UART with TX/RX FIFOs, runtime bit-period divisor and sticky RX error flags.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [DIV_W-1:0]              divisor,
  output logic                          tx,
  input  logic                          rx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clear
);

  logic [DIV_W-1:0] eff_div;
  assign eff_div = (divisor < DIV_W'(MIN_DIVISOR)) ? DIV_W'(MIN_DIVISOR) : divisor;

  // ---------------- TX path ----------------
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_last_stop;
  logic [DATA_BITS-1:0] tx_head, tx_shift;
  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_div, tx_cnt;
  logic [2:0]           tx_bit;
  logic                 tx_par, tx_stop_cnt;

  assign tx_ready     = !tx_full;
  assign tx_push      = tx_valid && tx_ready;
  assign tx_busy      = (tx_state != TX_IDLE) || !tx_empty;
  assign tx_last_stop = (STOP_BITS == 1) || tx_stop_cnt;
  assign tx_pop       = !tx_empty &&
                        ((tx_state == TX_IDLE) ||
                         (tx_state == TX_STOP && tx_cnt == '0 && tx_last_stop));

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level),
    .head  (tx_head)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_div      <= '0;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      tx_bit      <= '0;
      tx_par      <= 1'b0;
      tx_stop_cnt <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_pop) begin
            tx_state <= TX_START;
            tx       <= 1'b0;
            tx_div   <= eff_div;
            tx_cnt   <= eff_div - DIV_W'(1);
            tx_shift <= tx_head;
            tx_par   <= parity_bit(8'(tx_head), PARITY);
          end
        end
        default: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - DIV_W'(1);
          end else begin
            tx_cnt <= tx_div - DIV_W'(1);
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx       <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= '0;
              end
              TX_DATA: begin
                if (tx_bit == 3'(DATA_BITS - 1)) begin
                  if (PARITY != PARITY_NONE) begin
                    tx_state <= TX_PARITY;
                    tx       <= tx_par;
                  end else begin
                    tx_state    <= TX_STOP;
                    tx          <= 1'b1;
                    tx_stop_cnt <= 1'b0;
                  end
                end else begin
                  tx       <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 3'd1;
                end
              end
              TX_PARITY: begin
                tx_state    <= TX_STOP;
                tx          <= 1'b1;
                tx_stop_cnt <= 1'b0;
              end
              TX_STOP: begin
                if (!tx_last_stop) begin
                  tx_stop_cnt <= 1'b1;
                end else if (tx_pop) begin
                  // Chain straight into the next start bit with a freshly latched divisor.
                  tx_state <= TX_START;
                  tx       <= 1'b0;
                  tx_div   <= eff_div;
                  tx_cnt   <= eff_div - DIV_W'(1);
                  tx_shift <= tx_head;
                  tx_par   <= parity_bit(8'(tx_head), PARITY);
                end else begin
                  tx_state <= TX_IDLE;
                end
              end
              default: tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic                 rx_s1, rx_s2, rx_prev, rx_fall;
  logic                 rx_full, rx_empty, rx_pop, rx_push;
  rx_state_t            rx_state;
  logic [DIV_W-1:0]     rx_div, rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [2:0]           rx_bit;
  logic                 rx_par;

  assign rx_fall  = rx_prev && !rx_s2;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level),
    .head  (rx_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state   <= RX_IDLE;
      rx_div     <= '0;
      rx_cnt     <= '0;
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_par     <= 1'b0;
      rx_push    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      // Clearing first lets an error event later in this block take precedence.
      if (err_clear) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_div   <= eff_div;
            rx_cnt   <= eff_div >> 1;
          end
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - DIV_W'(1);
          end else begin
            rx_cnt <= rx_div - DIV_W'(1);
            case (rx_state)
              RX_START: begin
                if (rx_s2) begin
                  rx_state <= RX_IDLE;
                end else begin
                  rx_state <= RX_DATA;
                  rx_bit   <= '0;
                end
              end
              RX_DATA: begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == 3'(DATA_BITS - 1)) begin
                  rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                end else begin
                  rx_bit <= rx_bit + 3'd1;
                end
              end
              RX_PARITY: begin
                rx_par   <= rx_s2;
                rx_state <= RX_STOP;
              end
              RX_STOP: begin
                rx_state <= RX_IDLE;
                if (!rx_s2) begin
                  frame_err <= 1'b1;
                end else if (PARITY != PARITY_NONE &&
                             parity_bit(8'(rx_shift), PARITY) != rx_par) begin
                  parity_err <= 1'b1;
                end else begin
                  rx_push <= 1'b1;
                end
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overrun <= 1'b0;
    end else if (rx_push && rx_full && !rx_pop) begin
      overrun <= 1'b1;
    end else if (err_clear) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: an 8N1 instance for TX timing and an 8E1 depth-4 instance for RX.
module tb_uart_buffered;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [15:0] divisor = 16'd16;
  logic        err_clear = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  logic       tx_n, tx_valid_n, tx_ready_n, rx_valid_n, rx_ready_n, tx_busy_n;
  logic [7:0] tx_data_n, rx_data_n;
  logic [4:0] tx_level_n, rx_level_n;
  logic       frame_err_n, parity_err_n, overrun_n;

  logic       tx_e, rx_e, tx_valid_e, tx_ready_e, rx_valid_e, rx_ready_e, tx_busy_e;
  logic [7:0] tx_data_e, rx_data_e;
  logic [2:0] tx_level_e, rx_level_e;
  logic       frame_err_e, parity_err_e, overrun_e;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  assign rx_e = loop_en ? tx_e : rx_drv;

  uart_buffered #(.DIV_W(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_n (
    .clk(clk), .nrst(nrst), .divisor(divisor), .tx(tx_n), .rx(1'b1),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .tx_busy(tx_busy_n), .tx_level(tx_level_n), .rx_level(rx_level_n),
    .frame_err(frame_err_n), .parity_err(parity_err_n), .overrun(overrun_n),
    .err_clear(err_clear)
  );

  uart_buffered #(.DIV_W(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .nrst(nrst), .divisor(divisor), .tx(tx_e), .rx(rx_e),
    .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .tx_busy(tx_busy_e), .tx_level(tx_level_e), .rx_level(rx_level_e),
    .frame_err(frame_err_e), .parity_err(parity_err_e), .overrun(overrun_e),
    .err_clear(err_clear)
  );

  // Reference line level for bit slot idx of an 8N1 frame.
  function automatic logic exp_8n1(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Reference line level for bit slot idx of an 8E1 frame.
  function automatic logic exp_8e1(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise an 8E1 frame onto rx_drv at a 16-cycle bit period.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v);
    for (int i = 0; i < 11; i++) begin
      if (i == 9)       rx_drv = exp_8e1(d, 9) ^ bad_par;
      else if (i == 10) rx_drv = stop_v;
      else              rx_drv = exp_8e1(d, i);
      cyc(16);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    total++; if (tx_n !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx_n); end
    total++; if (tx_busy_n !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", tx_busy_n); end
    total++; if (tx_ready_n !== 1'b1 || tx_level_n !== 5'd0) begin bad++; $display("FAIL rst_txfifo: ready=%b level=%0d want 1/0", tx_ready_n, tx_level_n); end
    total++; if (rx_valid_e !== 1'b0 || rx_level_e !== 3'd0 || rx_data_e !== 8'h00) begin bad++; $display("FAIL rst_rxfifo: valid=%b level=%0d data=%h want 0/0/00", rx_valid_e, rx_level_e, rx_data_e); end
    total++; if ({frame_err_e, parity_err_e, overrun_e} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {frame_err_e, parity_err_e, overrun_e}); end
    @(negedge clk);
    nrst = 1'b1;
    cyc(2);
  endtask

  task automatic test_tx_frame();
    int start_at = -1;
    divisor = 16'd16;
    tx_data_n = 8'hA5; tx_valid_n = 1'b1;
    cyc(1);
    tx_valid_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_n === 1'b0) begin start_at = i; break; end
      cyc(1);
    end
    total++; if (start_at < 0) begin bad++; $display("FAIL a5_start: no start bit within 6 cycles"); end
    else begin
      total++; if (tx_busy_n !== 1'b1) begin bad++; $display("FAIL a5_busy: got %b want 1", tx_busy_n); end
      for (int k = 0; k < 176; k++) begin
        total++;
        if (tx_n !== exp_8n1(8'hA5, k / 16)) begin bad++; $display("FAIL a5_wave: cycle %0d got %b want %b", k, tx_n, exp_8n1(8'hA5, k / 16)); end
        cyc(1);
      end
      total++; if (tx_busy_n !== 1'b0) begin bad++; $display("FAIL a5_idle_busy: got %b want 0", tx_busy_n); end
    end
  endtask

  task automatic test_tx_divisor();
    int unsigned d, eff;
    logic [7:0] w;
    int start_at;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 1 : $urandom_range(2, 12);
      eff = (d < 4) ? 4 : d;
      w = 8'($urandom);
      start_at = -1;
      divisor = 16'(d);
      tx_data_n = w; tx_valid_n = 1'b1;
      cyc(1);
      tx_valid_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (tx_n === 1'b0) begin start_at = i; break; end
        cyc(1);
      end
      total++; if (start_at < 0) begin bad++; $display("FAIL div_start: div=%0d no start bit", d); end
      else begin
        // A divisor change during the frame must not affect it.
        divisor = 16'($urandom_range(4, 40));
        for (int k = 0; k < int'(10 * eff); k++) begin
          total++;
          if (tx_n !== exp_8n1(w, k / int'(eff))) begin bad++; $display("FAIL div_wave: div=%0d cycle %0d got %b want %b", d, k, tx_n, exp_8n1(w, k / int'(eff))); end
          cyc(1);
        end
        cyc(2);
        total++; if (tx_n !== 1'b1 || tx_busy_n !== 1'b0) begin bad++; $display("FAIL div_idle: tx=%b busy=%b want 1/0", tx_n, tx_busy_n); end
      end
    end
    divisor = 16'd16;
  endtask

  task automatic test_loopback();
    logic [7:0] w [4];
    int k = -1;
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h5A; w[3] = 8'($urandom);
    divisor = 16'd16;
    loop_en = 1'b1;
    cyc(2);
    for (int c = 0; c < 4 * 176 + 40; c++) begin
      if (c < 4) begin
        total++; if (tx_ready_e !== 1'b1) begin bad++; $display("FAIL loop_ready: word %0d got %b want 1", c, tx_ready_e); end
        tx_valid_e = 1'b1; tx_data_e = w[c];
      end else begin
        tx_valid_e = 1'b0;
      end
      cyc(1);
      if (k < 0 && tx_e === 1'b0) k = 0;
      if (k >= 0 && k < 4 * 176) begin
        total++;
        if (tx_e !== exp_8e1(w[k / 176], (k % 176) / 16)) begin bad++; $display("FAIL loop_wave: cycle %0d got %b want %b", k, tx_e, exp_8e1(w[k / 176], (k % 176) / 16)); end
        k++;
      end
    end
    total++; if (k != 4 * 176) begin bad++; $display("FAIL loop_len: observed %0d stream cycles want %0d", k, 4 * 176); end
    total++; if (rx_level_e !== 3'd4) begin bad++; $display("FAIL loop_level: got %0d want 4", rx_level_e); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_valid_e !== 1'b1 || rx_data_e !== w[i]) begin bad++; $display("FAIL loop_data: word %0d valid=%b got %h want %h", i, rx_valid_e, rx_data_e, w[i]); end
      rx_ready_e = 1'b1; cyc(1); rx_ready_e = 1'b0;
    end
    total++; if ({frame_err_e, parity_err_e, overrun_e, rx_valid_e} !== 4'b0000) begin bad++; $display("FAIL loop_flags: fe/pe/ov/valid=%b want 0000", {frame_err_e, parity_err_e, overrun_e, rx_valid_e}); end
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err();
    send_frame(8'($urandom), 1'b0, 1'b0);
    cyc(20);
    total++; if (frame_err_e !== 1'b1 || parity_err_e !== 1'b0) begin bad++; $display("FAIL ferr_set: fe=%b pe=%b want 1/0", frame_err_e, parity_err_e); end
    total++; if (rx_level_e !== 3'd0) begin bad++; $display("FAIL ferr_level: got %0d want 0", rx_level_e); end
    pulse_clear();
    total++; if (frame_err_e !== 1'b0) begin bad++; $display("FAIL ferr_clear: got %b want 0", frame_err_e); end
  endtask

  task automatic test_parity_err();
    send_frame(8'($urandom), 1'b1, 1'b1);
    cyc(20);
    total++; if (parity_err_e !== 1'b1 || frame_err_e !== 1'b0) begin bad++; $display("FAIL perr_set: pe=%b fe=%b want 1/0", parity_err_e, frame_err_e); end
    total++; if (rx_level_e !== 3'd0) begin bad++; $display("FAIL perr_level: got %0d want 0", rx_level_e); end
    pulse_clear();
    total++; if (parity_err_e !== 1'b0) begin bad++; $display("FAIL perr_clear: got %b want 0", parity_err_e); end
  endtask

  task automatic test_break();
    logic [7:0] w;
    w = 8'($urandom);
    rx_drv = 1'b0;
    cyc(320);
    total++; if (frame_err_e !== 1'b1) begin bad++; $display("FAIL brk_set: got %b want 1", frame_err_e); end
    pulse_clear();
    cyc(200);
    total++; if (frame_err_e !== 1'b0 || rx_level_e !== 3'd0) begin bad++; $display("FAIL brk_rearm: fe=%b level=%0d want 0/0", frame_err_e, rx_level_e); end
    rx_drv = 1'b1;
    cyc(20);
    send_frame(w, 1'b0, 1'b1);
    cyc(20);
    total++; if (rx_level_e !== 3'd1 || rx_data_e !== w) begin bad++; $display("FAIL brk_after: level=%0d data=%h want 1/%h", rx_level_e, rx_data_e, w); end
    rx_ready_e = 1'b1; cyc(1); rx_ready_e = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    rx_ready_e = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(w[i], 1'b0, 1'b1);
    cyc(20);
    total++; if (rx_level_e !== 3'd4) begin bad++; $display("FAIL ovr_level: got %0d want 4", rx_level_e); end
    total++; if (overrun_e !== 1'b1 || frame_err_e !== 1'b0 || parity_err_e !== 1'b0) begin bad++; $display("FAIL ovr_flags: ov=%b fe=%b pe=%b want 1/0/0", overrun_e, frame_err_e, parity_err_e); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_valid_e !== 1'b1 || rx_data_e !== w[i]) begin bad++; $display("FAIL ovr_data: word %0d valid=%b got %h want %h", i, rx_valid_e, rx_data_e, w[i]); end
      rx_ready_e = 1'b1; cyc(1); rx_ready_e = 1'b0;
    end
    total++; if (rx_valid_e !== 1'b0) begin bad++; $display("FAIL ovr_drain: valid=%b want 0", rx_valid_e); end
    pulse_clear();
    total++; if (overrun_e !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun_e); end
  endtask

  task automatic test_glitch();
    logic [7:0] w;
    w = 8'($urandom);
    divisor = 16'd16;
    rx_drv = 1'b0;
    cyc(3);
    rx_drv = 1'b1;
    cyc(40);
    total++; if (rx_level_e !== 3'd0 || {frame_err_e, parity_err_e, overrun_e} !== 3'b000) begin bad++; $display("FAIL glitch: level=%0d flags=%b want 0/000", rx_level_e, {frame_err_e, parity_err_e, overrun_e}); end
    send_frame(w, 1'b0, 1'b1);
    cyc(20);
    total++; if (rx_level_e !== 3'd1 || rx_data_e !== w) begin bad++; $display("FAIL glitch_after: level=%0d data=%h want 1/%h", rx_level_e, rx_data_e, w); end
    rx_ready_e = 1'b1; cyc(1); rx_ready_e = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    int highs = 0;
    divisor = 16'd16;
    for (int i = 0; i < 3; i++) begin
      tx_data_n = 8'($urandom); tx_valid_n = 1'b1;
      cyc(1);
    end
    tx_valid_n = 1'b0;
    total++; if (tx_level_n !== 5'd2) begin bad++; $display("FAIL mid_level: got %0d want 2", tx_level_n); end
    cyc(40);
    #2 nrst = 1'b0;
    #1;
    total++; if (tx_n !== 1'b1 || tx_level_n !== 5'd0 || tx_busy_n !== 1'b0) begin bad++; $display("FAIL mid_reset: tx=%b level=%0d busy=%b want 1/0/0", tx_n, tx_level_n, tx_busy_n); end
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (tx_n === 1'b1) highs++;
    end
    total++; if (highs != 60 || tx_level_n !== 5'd0) begin bad++; $display("FAIL mid_after: high cycles=%0d level=%0d want 60/0", highs, tx_level_n); end
  endtask

  initial begin
    tx_valid_n = 1'b0; tx_data_n = '0; rx_ready_n = 1'b0;
    tx_valid_e = 1'b0; tx_data_e = '0; rx_ready_e = 1'b0;
    test_reset();
    test_tx_frame();
    test_tx_divisor();
    test_loopback();
    test_frame_err();
    test_parity_err();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
